// File: rtl/fpu_inq_pkg.sv
// fpu_inq_pkg: shared constants, beat/entry field positions and FSM encoding for the FPU input queue.
package fpu_inq_pkg;

    localparam logic [4:0] FPU_REQ_TYPE = 5'b01010;

    localparam int BEAT_W  = 124;
    localparam int VLD     = 123;
    localparam int TYPE_HI = 122;
    localparam int TYPE_LO = 118;
    localparam int HDR_HI  = 91;
    localparam int HDR_LO  = 64;
    localparam int DATA_HI = 63;
    localparam int TWO_OP  = HDR_HI;

    localparam int ENT_W      = 156;
    localparam int ENT_RS2_LO = 92;
    localparam int ENT_RS1_LO = 28;
    localparam int HDR_W      = 28;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_B1 = 2'd1,
        DROP_B1 = 2'd2
    } state_t;

    function automatic logic is_fpu_hdr(input logic [BEAT_W-1:0] beat);
        return beat[VLD] && (beat[TYPE_HI:TYPE_LO] == FPU_REQ_TYPE);
    endfunction

endpackage

// File: rtl/fpu_inq_wr_ctl_if.sv
// fpu_inq_wr_ctl_if: PCX beat input, dequeue, inq_sram write port and queue status bundle.
interface fpu_inq_wr_ctl_if #(parameter int AW = 4);

    logic           pcx_fpio_data_rdy_px2;
    logic [123:0]   pcx_fpio_data_px2;
    logic           fpu_inq_deq;
    logic           inq_we;
    logic [AW-1:0]  inq_waddr;
    logic [155:0]   inq_din;
    logic [AW-1:0]  inq_raddr;
    logic           inq_empty;
    logic           inq_full;
    logic [AW:0]    inq_cnt;
    logic           fpu_pcx_credit_ret;
    logic           fpu_inq_err_ovf;
    logic           fpu_inq_err_proto;

    modport master (
        output pcx_fpio_data_rdy_px2, pcx_fpio_data_px2, fpu_inq_deq,
        input  inq_we, inq_waddr, inq_din, inq_raddr, inq_empty, inq_full, inq_cnt,
               fpu_pcx_credit_ret, fpu_inq_err_ovf, fpu_inq_err_proto
    );

    modport slave (
        input  pcx_fpio_data_rdy_px2, pcx_fpio_data_px2, fpu_inq_deq,
        output inq_we, inq_waddr, inq_din, inq_raddr, inq_empty, inq_full, inq_cnt,
               fpu_pcx_credit_ret, fpu_inq_err_ovf, fpu_inq_err_proto
    );

endinterface

// File: rtl/fpu_inq_ptr.sv
// fpu_inq_ptr: write/read pointers, occupancy, in-flight reservation, full/empty and credit return.
module fpu_inq_ptr #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          deq,
    input  logic          set_res,
    input  logic          clr_res,
    output logic [AW-1:0] wptr,
    output logic [AW-1:0] rptr,
    output logic [AW:0]   cnt,
    output logic          empty,
    output logic          full,
    output logic          credit_ret
);

    logic        res;
    logic        res_n;
    logic        pop;
    logic [AW:0] cnt_n;

    // A dequeue on an empty queue is dropped; full counts the slot held for a pending second beat.
    always_comb begin
        pop   = deq && (cnt != '0);
        cnt_n = cnt + (AW+1)'(push) - (AW+1)'(pop);
        res_n = set_res || (res && !clr_res);
    end

    // Status is registered from next-state values so it lines up with the write strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            cnt        <= '0;
            res        <= 1'b0;
            empty      <= 1'b1;
            full       <= 1'b0;
            credit_ret <= 1'b0;
        end else begin
            wptr       <= wptr + AW'(push);
            rptr       <= rptr + AW'(pop);
            cnt        <= cnt_n;
            res        <= res_n;
            empty      <= (cnt_n == '0);
            full       <= ((cnt_n + (AW+1)'(res_n)) == (AW+1)'(DEPTH));
            credit_ret <= pop;
        end
    end

endmodule

// File: rtl/fpu_inq_wr_ctl.sv
// fpu_inq_wr_ctl: assembles one/two-beat PCX FPU requests into 156-bit inq_sram entries.
module fpu_inq_wr_ctl #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic rclk,
    input  logic reset,
    fpu_inq_wr_ctl_if.slave bus
);

    import fpu_inq_pkg::*;

    state_t            state;
    state_t            state_n;
    logic              hdr_ok;
    logic              two_op;
    logic              full;
    logic              push;
    logic              push_pair;
    logic              set_res;
    logic              release_res;
    logic              set_ovf;
    logic [AW-1:0]     wptr;
    logic [HDR_W-1:0]  hdr_q;
    logic [DATA_HI:0]  rs1_q;

    assign hdr_ok = bus.pcx_fpio_data_rdy_px2 && is_fpu_hdr(bus.pcx_fpio_data_px2);
    assign two_op = bus.pcx_fpio_data_px2[TWO_OP];

    // State register; reset abandons any partially received packet.
    always_ff @(posedge rclk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Only a two-op header leaves IDLE; both beat-1 states last exactly one cycle.
    always_comb begin
        state_n = (state == IDLE && hdr_ok && two_op) ? (full ? DROP_B1 : WAIT_B1) : IDLE;
    end

    // Control decodes; full is the registered value so a same-cycle dequeue frees nothing.
    always_comb begin
        push_pair   = (state == WAIT_B1) && bus.pcx_fpio_data_rdy_px2;
        release_res = (state == WAIT_B1) && !bus.pcx_fpio_data_rdy_px2;
        set_res     = (state == IDLE) && hdr_ok && !full && two_op;
        set_ovf     = (state == IDLE) && hdr_ok && full;
        push        = push_pair || ((state == IDLE) && hdr_ok && !full && !two_op);
    end

    // Write port, header/rs1 holding registers and sticky error flags.
    always_ff @(posedge rclk) begin
        if (reset) begin
            bus.inq_we            <= 1'b0;
            bus.inq_waddr         <= '0;
            bus.inq_din           <= '0;
            hdr_q                 <= '0;
            rs1_q                 <= '0;
            bus.fpu_inq_err_ovf   <= 1'b0;
            bus.fpu_inq_err_proto <= 1'b0;
        end else begin
            bus.inq_we <= push;
            if (push) begin
                bus.inq_waddr <= wptr;
                bus.inq_din   <= push_pair
                    ? {bus.pcx_fpio_data_px2[DATA_HI:0], rs1_q, hdr_q}
                    : {64'd0, bus.pcx_fpio_data_px2[DATA_HI:0], bus.pcx_fpio_data_px2[HDR_HI:HDR_LO]};
            end
            if (set_res) begin
                hdr_q <= bus.pcx_fpio_data_px2[HDR_HI:HDR_LO];
                rs1_q <= bus.pcx_fpio_data_px2[DATA_HI:0];
            end
            if (set_ovf)     bus.fpu_inq_err_ovf   <= 1'b1;
            if (release_res) bus.fpu_inq_err_proto <= 1'b1;
        end
    end

    fpu_inq_ptr #(.DEPTH(DEPTH), .AW(AW)) u_ptr (
        .clk        (rclk),
        .rst        (reset),
        .push       (push),
        .deq        (bus.fpu_inq_deq),
        .set_res    (set_res),
        .clr_res    (push_pair || release_res),
        .wptr       (wptr),
        .rptr       (bus.inq_raddr),
        .cnt        (bus.inq_cnt),
        .empty      (bus.inq_empty),
        .full       (full),
        .credit_ret (bus.fpu_pcx_credit_ret)
    );

    assign bus.inq_full = full;

endmodule
